hll_layer_accumulator: RTL

Upstream feeder for the 3D HLL cell. Accepts a stream of (layer, hash) tokens, sets one bit per token in a per-layer HASH_WIDTH-bit live register, and on request seals the live set into a double-buffered snapshot. The snapshot bus `snap_registers` drives `layer_registers` of the vertical-entanglement cell directly, and live accumulation continues while a snapshot is held.

---
 rtl/hll_pkg.sv | 27 ++
 rtl/hll_onehot_decode.sv | 21 ++
 rtl/hll_layer_accumulator.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/hll_pkg.sv
// Shared types and helpers for the HLL layer accumulator slice.
package hll_pkg;

    localparam int HLL_HASH_IN_W  = 64;
    localparam int HLL_CNT_W      = 16;
    localparam int HLL_LAYER_ID_W = 8;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } hll_acc_state_t;

    typedef logic [HLL_LAYER_ID_W-1:0] hll_layer_id_t;

    // Saturating increment so a flooded layer pins at all-ones instead of wrapping.
    function automatic logic [HLL_CNT_W-1:0] hll_sat_inc(
        input logic [HLL_CNT_W-1:0] cnt,
        input logic                 inc
    );
        if (inc && (cnt != {HLL_CNT_W{1'b1}})) begin
            return cnt + {{(HLL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return cnt;
        end
    endfunction

endpackage

// File: rtl/hll_onehot_decode.sv
// Enable-qualified binary index to one-hot decoder.
module hll_onehot_decode #(
    parameter int WIDTH = 64,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [WIDTH-1:0] onehot
);

    // Single set bit at idx when enabled, all zeros otherwise.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/hll_layer_accumulator.sv
// Per-layer hash bitmap accumulator with double-buffered sealed snapshot.
// Optional per-layer token counters are enabled with `define HLL_ACC_COUNT_EN.
module hll_layer_accumulator
    import hll_pkg::*;
#(
    parameter int NUM_LAYERS = 8,
    parameter int HASH_WIDTH = 64,
    parameter int IDX_W      = $clog2(HASH_WIDTH),
    parameter int LAYER_W    = $clog2(NUM_LAYERS)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [LAYER_W-1:0]                     in_layer,
    input  logic [HLL_HASH_IN_W-1:0]               in_hash,
    input  logic                                   seal_req,
    output logic                                   snap_valid,
    input  logic                                   snap_ready,
    output logic [NUM_LAYERS-1:0][HASH_WIDTH-1:0]  snap_registers,
    output logic                                   seal_pending,
    output logic                                   err_drop
`ifdef HLL_ACC_COUNT_EN
    ,
    output logic [NUM_LAYERS-1:0][HLL_CNT_W-1:0]   snap_count
`endif
);

    hll_acc_state_t state_r, state_nxt_s;

    logic ready_r, snap_valid_r, seal_pending_r, err_drop_r;
    logic snap_valid_nxt_s, seal_pending_nxt_s, do_seal_s;
    logic accept_s, in_range_s, hit_en_s;
    logic unused_hash_s;

    logic [HASH_WIDTH-1:0]                  onehot_s;
    logic [NUM_LAYERS-1:0]                  layer_hit_s;
    logic [NUM_LAYERS-1:0][HASH_WIDTH-1:0]  token_bits_s;
    logic [NUM_LAYERS-1:0][HASH_WIDTH-1:0]  live_r;
    logic [NUM_LAYERS-1:0][HASH_WIDTH-1:0]  snap_r;

    assign accept_s      = in_valid & ready_r;
    assign in_range_s    = (hll_layer_id_t'(in_layer) < hll_layer_id_t'(NUM_LAYERS));
    assign hit_en_s      = accept_s & in_range_s;
    assign unused_hash_s = ^in_hash[HLL_HASH_IN_W-1:IDX_W];

    hll_onehot_decode #(
        .WIDTH (HASH_WIDTH),
        .IDX_W (IDX_W)
    ) u_decode (
        .idx    (in_hash[IDX_W-1:0]),
        .en     (hit_en_s),
        .onehot (onehot_s)
    );

    // Steer the shared one-hot into the addressed layer only.
    always_comb begin
        layer_hit_s  = '0;
        token_bits_s = '0;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            layer_hit_s[l]  = hit_en_s & (hll_layer_id_t'(in_layer) == hll_layer_id_t'(l));
            token_bits_s[l] = onehot_s & {HASH_WIDTH{layer_hit_s[l]}};
        end
    end

    // Seal/handshake control; a seal in HOLD only fires on the accept edge.
    always_comb begin
        state_nxt_s        = state_r;
        do_seal_s          = 1'b0;
        snap_valid_nxt_s   = snap_valid_r;
        seal_pending_nxt_s = seal_pending_r;
        case (state_r)
            ACCUM: begin
                if (seal_req) begin
                    do_seal_s        = 1'b1;
                    snap_valid_nxt_s = 1'b1;
                    state_nxt_s      = HOLD;
                end else begin
                    state_nxt_s      = ACCUM;
                end
            end
            HOLD: begin
                if (snap_ready) begin
                    seal_pending_nxt_s = 1'b0;
                    if (seal_pending_r || seal_req) begin
                        do_seal_s        = 1'b1;
                        snap_valid_nxt_s = 1'b1;
                    end else begin
                        snap_valid_nxt_s = 1'b0;
                        state_nxt_s      = ACCUM;
                    end
                end else begin
                    seal_pending_nxt_s = seal_pending_r | seal_req;
                end
            end
            default: begin
                state_nxt_s        = ACCUM;
                snap_valid_nxt_s   = 1'b0;
                seal_pending_nxt_s = 1'b0;
            end
        endcase
    end

    // Control state and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ACCUM;
            ready_r        <= 1'b0;
            snap_valid_r   <= 1'b0;
            seal_pending_r <= 1'b0;
            err_drop_r     <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            ready_r        <= 1'b1;
            snap_valid_r   <= snap_valid_nxt_s;
            seal_pending_r <= seal_pending_nxt_s;
            err_drop_r     <= accept_s & ~in_range_s;
        end
    end

    // Live bitmap and snapshot; the seal-cycle token lands in the snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_r <= '0;
            snap_r <= '0;
        end else if (do_seal_s) begin
            snap_r <= live_r | token_bits_s;
            live_r <= '0;
        end else begin
            live_r <= live_r | token_bits_s;
        end
    end

`ifdef HLL_ACC_COUNT_EN
    logic [NUM_LAYERS-1:0][HLL_CNT_W-1:0] cnt_live_r, cnt_nxt_s, cnt_snap_r;

    // Next live count per layer, saturating.
    always_comb begin
        cnt_nxt_s = '0;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            cnt_nxt_s[l] = hll_sat_inc(cnt_live_r[l], layer_hit_s[l]);
        end
    end

    // Counters follow the bitmap: copied and zeroed on the same seal edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_live_r <= '0;
            cnt_snap_r <= '0;
        end else if (do_seal_s) begin
            cnt_snap_r <= cnt_nxt_s;
            cnt_live_r <= '0;
        end else begin
            cnt_live_r <= cnt_nxt_s;
        end
    end

    assign snap_count = cnt_snap_r;
`endif

    assign in_ready       = ready_r;
    assign snap_valid     = snap_valid_r;
    assign seal_pending   = seal_pending_r;
    assign err_drop       = err_drop_r;
    assign snap_registers = snap_r;

endmodule
